ascon_phase_ctrl: RTL

- Sequences the Ascon-128 encryption datapath through its phases: load, init, key-xor, AD absorb, domain separation, PT absorb/CT squeeze, final key-xor, finalization and tag.
- Drives a one-round-per-cycle permutation state register and its XOR-in muxes.
- Sits between the serial-load wrapper (which asserts start once key, nonce, AD and PT are shifted in) and the permutation/state datapath.
- Holds the tag until the output serializer accepts it.

---
 rtl/ascon_phase_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ascon_phase_ctrl.sv
// Phase sequencer for the Ascon-128 encryption datapath: steps the one-round-per-cycle
// permutation and its XOR-in strobes from IV load through tag hand-off.
module ascon_phase_ctrl #(
    parameter int A = 12,
    parameter int B = 6,
    parameter int R = 64,
    parameter int L = 32,
    parameter int Y = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       out_ready,
    output logic       ready,
    output logic       load_init,
    output logic       round_en,
    output logic [3:0] round_idx,
    output logic       xor_key_tail,
    output logic       absorb_ad,
    output logic       dom_sep,
    output logic       absorb_pt,
    output logic       ct_valid,
    output logic       xor_key_final,
    output logic [7:0] blk_idx,
    output logic       tag_valid,
    output logic       done,
    output logic       busy
);

    localparam int NAD = (L == 0) ? 0 : (L + R) / R;
    localparam int NPT = (Y + R) / R;

    localparam logic [3:0] A_LAST   = 4'(A - 1);
    localparam logic [3:0] B_LAST   = 4'(B - 1);
    localparam logic [3:0] A_BASE   = 4'(12 - A);
    localparam logic [3:0] B_BASE   = 4'(12 - B);
    localparam logic [7:0] NAD_LAST = 8'(NAD - 1);
    localparam logic [7:0] NPT_LAST = 8'(NPT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_INIT, S_IKEY, S_ADX, S_ADR,
        S_SEP, S_PTX, S_PTR, S_FKEY, S_FIN, S_TAG
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] rnd_q, rnd_d;
    logic [7:0] blk_q, blk_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rnd_q   <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            blk_q   <= blk_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rnd_d         = rnd_q;
        blk_d         = blk_q;
        ready         = 1'b0;
        load_init     = 1'b0;
        round_en      = 1'b0;
        round_idx     = '0;
        xor_key_tail  = 1'b0;
        absorb_ad     = 1'b0;
        dom_sep       = 1'b0;
        absorb_pt     = 1'b0;
        ct_valid      = 1'b0;
        xor_key_final = 1'b0;
        tag_valid     = 1'b0;
        done          = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                load_init = 1'b1;
                state_d   = S_INIT;
            end
            S_INIT, S_FIN: begin
                round_en  = 1'b1;
                round_idx = A_BASE + rnd_q;
                if (rnd_q == A_LAST) begin
                    rnd_d   = '0;
                    state_d = (state_q == S_INIT) ? S_IKEY : S_TAG;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            S_IKEY: begin
                xor_key_tail = 1'b1;
                if (NAD > 0) begin
                    blk_d   = '0;
                    state_d = S_ADX;
                end else begin
                    state_d = S_SEP;
                end
            end
            S_ADX: begin
                absorb_ad = 1'b1;
                state_d   = S_ADR;
            end
            // Block index advances only when another block of the same kind follows.
            S_ADR, S_PTR: begin
                round_en  = 1'b1;
                round_idx = B_BASE + rnd_q;
                if (rnd_q == B_LAST) begin
                    rnd_d = '0;
                    if (state_q == S_PTR) begin
                        blk_d   = blk_q + 8'd1;
                        state_d = S_PTX;
                    end else if (blk_q == NAD_LAST) begin
                        state_d = S_SEP;
                    end else begin
                        blk_d   = blk_q + 8'd1;
                        state_d = S_ADX;
                    end
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            S_SEP: begin
                dom_sep = 1'b1;
                blk_d   = '0;
                state_d = S_PTX;
            end
            S_PTX: begin
                absorb_pt = 1'b1;
                ct_valid  = 1'b1;
                state_d   = (blk_q == NPT_LAST) ? S_FKEY : S_PTR;
            end
            S_FKEY: begin
                xor_key_final = 1'b1;
                state_d       = S_FIN;
            end
            S_TAG: begin
                tag_valid = 1'b1;
                if (out_ready) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign blk_idx = blk_q;
    assign busy    = ~ready;

endmodule
